// File: rtl/sram_controller.sv
// Bridges 32-bit MEM-stage loads/stores to a 16-bit asynchronous SRAM.
// Each access runs as two PHASE_CYCLES-long halfword phases, low half first.
module sram_controller #(
  parameter int PHASE_CYCLES = 2,
  parameter int MEM_BASE     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(PHASE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [16:0]   word_q, word_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          is_wr_q, is_wr_d;
  logic [31:0]   buf_q, buf_d;
  logic [31:0]   read_data_q, read_data_d;

  logic in_phase;
  logic last_cyc;

  assign in_phase = (state_q == LOW) || (state_q == HIGH);
  assign last_cyc = (cnt_q == LAST_CNT);

  // NOTE: every variable gets its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    is_wr_d     = is_wr_q;
    buf_d       = buf_q;
    read_data_d = read_data_q;
    unique case (state_q)
      IDLE: begin
        if (rd_en || wr_en) begin
          state_d = LOW;
          cnt_d   = '0;
          // Word bits above 16 drop out here, so accesses wrap modulo 2^17 words.
          word_d  = 17'((address - 32'(MEM_BASE)) >> 2);
          wdata_d = write_data;
          is_wr_d = wr_en;
        end
      end
      LOW: begin
        cnt_d = cnt_q + 1'b1;
        if (last_cyc) begin
          state_d = HIGH;
          cnt_d   = '0;
          if (!is_wr_q) buf_d[15:0] = SRAM_DQ;
        end
      end
      HIGH: begin
        cnt_d = cnt_q + 1'b1;
        if (last_cyc) begin
          state_d = DONE;
          cnt_d   = '0;
          if (!is_wr_q) begin
            buf_d[31:16] = SRAM_DQ;
            read_data_d  = buf_d;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
      wdata_q     <= '0;
      is_wr_q     <= 1'b0;
      buf_q       <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      is_wr_q     <= is_wr_d;
      buf_q       <= buf_d;
      read_data_q <= read_data_d;
    end
  end

  // Strobes decode straight from state, so an async reset releases the SRAM at once.
  assign SRAM_CE_N = !in_phase;
  assign SRAM_WE_N = !(in_phase && is_wr_q && !last_cyc);
  assign SRAM_OE_N = !(in_phase && !is_wr_q);
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_ADDR = in_phase ? {word_q, state_q == HIGH} : '0;
  assign SRAM_DQ   = (in_phase && is_wr_q)
                     ? ((state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0])
                     : 16'hzzzz;

  assign read_data = read_data_q;
  assign ready     = ((state_q == IDLE) && !rd_en && !wr_en) || (state_q == DONE);

endmodule
